// File: rtl/sram_pkg.sv
// Shared types and sizes for the two-port SRAM front-end controller.
package sram_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCapt
  } state_e;

  typedef enum logic {
    PortA,
    PortB
  } port_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;

endpackage

// File: rtl/sram_2port_ctrl_if.sv
// Request ports A/B plus the array-side bus; master is the requester/array side,
// slave is the controller.
interface sram_2port_ctrl_if;
  import sram_pkg::*;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [DEPTH-1:0]  wordA;
  logic [DEPTH-1:0]  wordB;
  logic              ReadEn;
  logic              WriteEn;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] outA;
  logic [DATA_W-1:0] outB;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output outA, outB,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  wordA, wordB, ReadEn, WriteEn, in
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  outA, outB,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output wordA, wordB, ReadEn, WriteEn, in
  );

endinterface

// File: rtl/sram_addr_decoder.sv
// Binary row address to one-hot word-line select; all-zero when disabled.
module sram_addr_decoder
  import sram_pkg::*;
(
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DEPTH-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_2port_ctrl.sv
// Round-robin two-port front end: one op per 3 cycles (IDLE -> DRIVE -> CAPT),
// array strobes and port responses all come straight from flops.
module sram_2port_ctrl
  import sram_pkg::*;
(
  input logic              srclkpos,
  input logic              srrstneg,
  sram_2port_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  port_e             last_q, last_d;
  port_e             owner_q, owner_d;
  logic              rd_q, rd_d;

  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic [DEPTH-1:0]  word_q, word_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;

  port_e             win_port;
  op_t               win_op;
  logic              accept;
  logic [DEPTH-1:0]  row_sel;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    if (bus.a_req && bus.b_req) begin
      win_port = (last_q == PortA) ? PortB : PortA;
    end else if (bus.a_req) begin
      win_port = PortA;
    end else begin
      win_port = PortB;
    end
  end

  always_comb begin
    if (win_port == PortA) begin
      win_op.we    = bus.a_we;
      win_op.addr  = bus.a_addr;
      win_op.wdata = bus.a_wdata;
    end else begin
      win_op.we    = bus.b_we;
      win_op.addr  = bus.b_addr;
      win_op.wdata = bus.b_wdata;
    end
  end

  assign accept = (state_q == StIdle) && (bus.a_req || bus.b_req);

  sram_addr_decoder u_dec (
    .en_i    (accept),
    .addr_i  (win_op.addr),
    .onehot_o(row_sel)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    rd_d       = rd_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    word_d     = '0;
    re_d       = 1'b0;
    we_d       = 1'b0;
    din_d      = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StDrive;
          last_d  = win_port;
          owner_d = win_port;
          rd_d    = ~win_op.we;
          a_gnt_d = (win_port == PortA);
          b_gnt_d = (win_port == PortB);
          word_d  = row_sel;
          re_d    = ~win_op.we;
          we_d    = win_op.we;
          din_d   = win_op.we ? win_op.wdata : '0;
        end
      end
      StDrive: begin
        state_d = StCapt;
        // outA is valid while ReadEn is high, i.e. throughout this cycle.
        if (rd_q) begin
          if (owner_q == PortA) begin
            a_rdata_d  = bus.outA;
            a_rvalid_d = 1'b1;
          end else begin
            b_rdata_d  = bus.outA;
            b_rvalid_d = 1'b1;
          end
        end
      end
      StCapt: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge srclkpos) begin
    if (!srrstneg) begin
      state_q    <= StIdle;
      last_q     <= PortB;
      owner_q    <= PortA;
      rd_q       <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      word_q     <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      rd_q       <= rd_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      word_q     <= word_d;
      re_q       <= re_d;
      we_q       <= we_d;
      din_q      <= din_d;
    end
  end

  assign bus.a_gnt    = a_gnt_q;
  assign bus.b_gnt    = b_gnt_q;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.wordA    = word_q;
  assign bus.wordB    = word_q;
  assign bus.ReadEn   = re_q;
  assign bus.WriteEn  = we_q;
  assign bus.in       = din_q;

  a_no_rw_overlap: assert property (@(posedge srclkpos) !(re_q && we_q));
  a_word_onehot0:  assert property (@(posedge srclkpos) $onehot0(word_q));
  a_strobe_word:   assert property (@(posedge srclkpos) (re_q || we_q) == (word_q != '0));

endmodule

// File: tb/tb_sram_2port_ctrl.sv
// Randomized bench for sram_2port_ctrl with a transaction-schedule reference model
// and a behavioural 32x16 array hanging off the array bus.
module tb_sram_2port_ctrl;
  import sram_pkg::*;

  logic clk = 1'b0;
  logic srrstneg = 1'b0;
  logic chk_en = 1'b0;
  always #5 clk = ~clk;

  sram_2port_ctrl_if bus ();

  sram_2port_ctrl dut (
    .srclkpos(clk),
    .srrstneg(srrstneg),
    .bus     (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned timeouts = 0;
  int unsigned cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return 16'hA500 ^ 16'(i * 7);
  endfunction

  function automatic logic [1:0] sl(input int unsigned c);
    return c[1:0];
  endfunction

  // Behavioural array: combinational read, write on the clock edge.
  logic [DATA_W-1:0] arr [DEPTH];

  always_comb begin
    bus.outA = '0;
    bus.outB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.ReadEn && bus.wordA[i]) bus.outA = arr[i];
      if (bus.ReadEn && bus.wordB[i]) bus.outB = arr[i];
    end
  end

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= init_val(i);
    end else if (bus.WriteEn) begin
      for (int i = 0; i < DEPTH; i++) if (bus.wordA[i]) arr[i] <= bus.in;
    end
  end

  // Reference model: per-cycle expectations scheduled at acceptance time.
  typedef struct packed {
    logic              ga, gb, re, we;
    logic [31:0]       word;
    logic [DATA_W-1:0] din;
    logic              rva, rvb;
    logic [DATA_W-1:0] rd;
  } slot_t;

  slot_t             slots [4];
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] hold_a = '0;
  logic [DATA_W-1:0] hold_b = '0;
  logic              last_b = 1'b1;
  int unsigned       free_at = 0;

  logic              pick_b;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd;

  always_comb begin
    pick_b = (bus.a_req && bus.b_req) ? !last_b : !bus.a_req;
    m_we   = pick_b ? bus.b_we : bus.a_we;
    m_addr = pick_b ? bus.b_addr : bus.a_addr;
    m_wd   = pick_b ? bus.b_wdata : bus.a_wdata;
  end

  function automatic slot_t drive_slot(input logic pb, input logic we,
                                       input logic [ADDR_W-1:0] addr,
                                       input logic [DATA_W-1:0] wd);
    slot_t s = '0;
    s.ga   = !pb;
    s.gb   = pb;
    s.we   = we;
    s.re   = !we;
    s.word = 32'd1 << addr;
    s.din  = we ? wd : '0;
    return s;
  endfunction

  function automatic slot_t capt_slot(input logic pb, input logic we,
                                      input logic [DATA_W-1:0] rd);
    slot_t s = '0;
    if (!we) begin
      s.rva = !pb;
      s.rvb = pb;
      s.rd  = rd;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] <= init_val(i);
    end
    if (!srrstneg) begin
      for (int i = 0; i < 4; i++) slots[i] <= '0;
      hold_a  <= '0;
      hold_b  <= '0;
      last_b  <= 1'b1;
      free_at <= cyc + 2;
    end else begin
      if (slots[sl(cyc + 1)].rva) hold_a <= slots[sl(cyc + 1)].rd;
      if (slots[sl(cyc + 1)].rvb) hold_b <= slots[sl(cyc + 1)].rd;
      slots[sl(cyc + 3)] <= '0;
      if ((bus.a_req || bus.b_req) && (cyc + 1 >= free_at)) begin
        free_at <= cyc + 4;
        last_b  <= pick_b;
        if (m_we) mem_m[m_addr] <= m_wd;
        slots[sl(cyc + 1)] <= drive_slot(pick_b, m_we, m_addr, m_wd);
        slots[sl(cyc + 2)] <= capt_slot(pick_b, m_we, mem_m[m_addr]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_gnt",    32'(bus.a_gnt),    32'(slots[sl(cyc)].ga));
      check("b_gnt",    32'(bus.b_gnt),    32'(slots[sl(cyc)].gb));
      check("ReadEn",   32'(bus.ReadEn),   32'(slots[sl(cyc)].re));
      check("WriteEn",  32'(bus.WriteEn),  32'(slots[sl(cyc)].we));
      check("wordA",    bus.wordA,         slots[sl(cyc)].word);
      check("wordB",    bus.wordB,         slots[sl(cyc)].word);
      check("in",       32'(bus.in),       32'(slots[sl(cyc)].din));
      check("a_rvalid", 32'(bus.a_rvalid), 32'(slots[sl(cyc)].rva));
      check("b_rvalid", 32'(bus.b_rvalid), 32'(slots[sl(cyc)].rvb));
      check("a_rdata",  32'(bus.a_rdata),  32'(hold_a));
      check("b_rdata",  32'(bus.b_rdata),  32'(hold_b));
    end
  end

  // Call at a falling edge; holds the request until its gnt is seen, then drops it.
  task automatic issue(input logic port_b, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd);
    logic seen = 1'b0;
    if (port_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = port_b ? bus.b_gnt : bus.a_gnt;
    end
    if (!seen) timeouts++;
    if (port_b) bus.b_req = 1'b0;
    else bus.a_req = 1'b0;
  endtask

  task automatic rand_port(input logic port_b, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(port_b, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    srrstneg = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    srrstneg = 1'b1;
    @(negedge clk);

    issue(1'b0, 1'b1, 5'd5, 16'hBEEF);
    issue(1'b0, 1'b0, 5'd5, 16'h0);
    issue(1'b1, 1'b1, 5'd9, 16'h1234);

    fork
      begin
        issue(1'b0, 1'b1, 5'd0, 16'h1111);
        issue(1'b0, 1'b1, 5'd0, 16'h1111);
      end
      begin
        issue(1'b1, 1'b0, 5'd0, 16'h0);
        issue(1'b1, 1'b0, 5'd0, 16'h0);
      end
    join

    issue(1'b0, 1'b1, 5'd0, 16'h0F0F);
    issue(1'b1, 1'b1, 5'd31, 16'hF00D);
    issue(1'b0, 1'b0, 5'd31, 16'h0);
    issue(1'b1, 1'b0, 5'd0, 16'h0);

    // Reset lands at the end of the DRIVE cycle of a read.
    fork
      issue(1'b0, 1'b0, 5'd9, 16'h0);
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (bus.a_gnt) break;
        end
        srrstneg = 1'b0;
      end
    join
    @(negedge clk);
    srrstneg = 1'b1;
    repeat (2) @(negedge clk);

    fork
      issue(1'b0, 1'b0, 5'd31, 16'h0);
      issue(1'b1, 1'b0, 5'd5, 16'h0);
    join

    fork
      rand_port(1'b0, 120);
      rand_port(1'b1, 120);
    join

    repeat (4) @(negedge clk);
    check("gnt_timeouts", 32'(timeouts), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_2port_ctrl.md
Name: sram_2port_ctrl

Overview:
Synchronous front-end controller that sits directly upstream of the 32x16 two-port SRAM array. It accepts read/write requests from two independent ports (A, B) with a req/gnt handshake and round-robin arbitration. It serialises the winning operation onto the array's one-hot word lines and read/write enables, then captures the array read data and returns it to the owning port with an rvalid pulse.

Parameters:
ADDR_W, 5, address width per port
DATA_W, 16, data word width
DEPTH, 32, number of rows; fixed at 2**ADDR_W

Ports:
srclkpos  in  1  single clock; all state updates on rising edge
srrstneg  in  1  synchronous, active-low reset
a_req  in  1  port A request; held with a_we/a_addr/a_wdata stable until a_gnt is seen
a_we  in  1  port A op: 1 = write, 0 = read
a_addr  in  ADDR_W  port A row address
a_wdata  in  DATA_W  port A write data
a_gnt  out  1  one-cycle pulse: port A request accepted
a_rvalid  out  1  one-cycle pulse: a_rdata holds read result
a_rdata  out  DATA_W  port A read data; holds last value otherwise
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  as port A, for port B
wordA  out  DEPTH  one-hot row select to array
wordB  out  DEPTH  one-hot row select to array; always equal to wordA
ReadEn  out  1  array read enable
WriteEn  out  1  array write enable
in  out  DATA_W  array write data
outA  in  DATA_W  array read data, combinationally valid while ReadEn is high
outB  in  DATA_W  array read data, second port; monitored only, not used for data return

Behaviour:
- Reset (srrstneg low at a rising edge): state = IDLE, last_served = B. All outputs 0: gnt, rvalid, rdata, wordA/B, ReadEn, WriteEn, in. Any in-flight op is dropped with no gnt and no rvalid, and the array sees no enable in the following cycle.
- FSM states: IDLE -> DRIVE -> CAPT -> IDLE. Every op takes exactly 3 cycles; the earliest back-to-back acceptance is every 3rd cycle.
- IDLE (cycle T): if a_req or b_req is high, arbitrate, latch port id, we, addr and wdata, and go to DRIVE. Otherwise stay in IDLE.
- Arbitration: a single requester wins. If both request, the port that is not last_served wins; last_served is updated to the winner at acceptance. After reset, a tie goes to A.
- DRIVE (T+1):
  - the winner's gnt is high for this cycle only
  - wordA = wordB = 1 << latched addr
  - read: ReadEn = 1, WriteEn = 0, in = 0; outA is sampled into the winner's rdata at the end of the cycle
  - write: WriteEn = 1, ReadEn = 0, in = latched wdata
- CAPT (T+2): all array outputs are 0. For a read, the winner's rvalid = 1 with rdata stable. Then go to IDLE.
- Array outputs (wordA/B, ReadEn, WriteEn, in) are registered and non-zero only in DRIVE. ReadEn and WriteEn are never both high.
- Read latency: rvalid is 2 cycles after the acceptance cycle. A write followed by a read of the same address returns the new data because ops are serialised.
- The losing port's req stays pending and is accepted in the next IDLE; no request is lost.
- rdata of the non-served port is unchanged.
- req sampled high outside IDLE has no effect until IDLE.
- Address range is full (32 rows); no out-of-range case exists. addr 0 gives wordA bit 0, addr 31 gives bit 31.

Decomposition:
- Package sram_pkg:
  - ADDR_W, DATA_W, DEPTH constants
  - enumerated state type {IDLE, DRIVE, CAPT}
  - port-id type {PORT_A, PORT_B}
  - op struct {we, addr, wdata}
- Sub-module sram_addr_decoder: ADDR_W binary to DEPTH one-hot with an enable input (zero when disabled). The decoder is combinational; its output is registered in the controller.

Test Plan:
- Reset then A write addr 5 data 0xBEEF: a_gnt at T+1; WriteEn=1 with wordA=wordB=0x0000_0020 and in=0xBEEF at T+1; all array outputs 0 at T+2.
- A read addr 5 after the above: ReadEn=1 with wordA=0x20 at T+1; a_rvalid=1 with a_rdata=0xBEEF at T+2; b_rvalid stays 0.
- A and B both request continuously (A write addr 0 0x1111, B read addr 0): A is granted first, then B. Grants alternate A,B,A,B at 3-cycle spacing; B's read returns 0x1111.
- Boundary addresses: writes to addr 0 and 31 -> wordA = 0x0000_0001 and 0x8000_0000 respectively; readback returns the written data.
- srrstneg low during DRIVE of a read: next cycle every output is 0 and no rvalid is ever pulsed for that op. A tie after reset grants A.
- Pending loser: B req held high while A is served -> b_gnt exactly 3 cycles after a_gnt; b_req held across states is accepted once only.
